// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the mult/div sequencer: FSM state encoding,
// exception register/codes and the mult/div ALU-op constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } md_state_e;

  localparam int unsigned RSTATUS_REG   = 30;
  localparam int unsigned MULT_EXC_CODE = 4;
  localparam int unsigned DIV_EXC_CODE  = 5;

  localparam logic [4:0] ALU_OP_MULT = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV  = 5'b00111;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Bundle between the sequencer, the iterative mult/div unit and the
// register-file write port. master = sequencer side, slave = unit/arbiter side.
interface multdiv_sequencer_if;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_grant;

  modport master (
    output ctrl_mult, ctrl_div, md_op_a, md_op_b, wb_valid, wb_reg, wb_data,
    input  md_ready, md_result, md_exception, wb_grant
  );

  modport slave (
    input  ctrl_mult, ctrl_div, md_op_a, md_op_b, wb_valid, wb_reg, wb_data,
    output md_ready, md_result, md_exception, wb_grant
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequences the shared iterative mult/div unit beside decode: latch, start,
// stall, then request the write port. MULTDIV_WATCHDOG_EN enables the WAIT timeout.
module multdiv_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned LATENCY       = 32,
  parameter int unsigned RSTATUS_REG   = cpu_pkg::RSTATUS_REG,
  parameter int unsigned MULT_EXC_CODE = cpu_pkg::MULT_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE  = cpu_pkg::DIV_EXC_CODE
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_multdiv_operands,
  input  logic                       is_div,
  input  logic [4:0]                 rd_in,
  input  logic [31:0]                op_a,
  input  logic [31:0]                op_b,
  output logic                       stall,
  output logic                       busy,
  multdiv_sequencer_if.master        bus
);

  localparam int unsigned CNT_W = $clog2(2 * LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef MULTDIV_WATCHDOG_EN
  localparam logic [CNT_W-1:0] CNT_TIMEOUT_LAST = CNT_W'(2 * LATENCY - 1);
`endif

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             kind_q;
  logic [4:0]       rd_q;
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  logic             ctrl_mult_q;
  logic             ctrl_div_q;
  logic             wb_valid_q;
  logic [4:0]       wb_reg_q;
  logic [31:0]      wb_data_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kind_q      <= 1'b0;
      rd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
    end else begin
      // Start pulses are set on the IDLE->START edge so they are high only in START.
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_multdiv_operands) begin
            op_a_q      <= op_a;
            op_b_q      <= op_b;
            rd_q        <= rd_in;
            kind_q      <= is_div;
            ctrl_div_q  <= is_div;
            ctrl_mult_q <= ~is_div;
            state_q     <= START;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if (bus.md_ready) begin
            if (bus.md_exception) begin
              wb_reg_q   <= 5'(RSTATUS_REG);
              wb_data_q  <= kind_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
              wb_valid_q <= 1'b1;
              state_q    <= WB;
            end else begin
              wb_reg_q  <= rd_q;
              wb_data_q <= bus.md_result;
              if (rd_q == '0) begin
                state_q <= IDLE;
              end else begin
                wb_valid_q <= 1'b1;
                state_q    <= WB;
              end
            end
          end
`ifdef MULTDIV_WATCHDOG_EN
          // Fires on the 2*LATENCY-th WAIT cycle; a ready in that same cycle wins.
          else if (cnt_q == CNT_TIMEOUT_LAST) begin
            wb_reg_q   <= 5'(RSTATUS_REG);
            wb_data_q  <= kind_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end
`endif
        end
        WB: begin
          if (bus.wb_grant) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign stall         = busy;
  assign bus.ctrl_mult = ctrl_mult_q;
  assign bus.ctrl_div  = ctrl_div_q;
  assign bus.md_op_a   = op_a_q;
  assign bus.md_op_b   = op_b_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_reg    = wb_reg_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Controller that sequences the shared iterative multiply/divide unit for the five-stage pipeline. It sits beside decode. When decode flags a mult/div R-type through `load_multdiv_operands`, it:
- latches the operands and destination,
- issues a one-cycle start to the unit,
- stalls fetch/decode until the result is ready,
- requests the register-file write port for the result or for the `rstatus` exception code.

## Interface
Parameters:
- `LATENCY`, 32: nominal multdiv cycles from start to ready.
- `RSTATUS_REG`, 30: exception destination register.
- `MULT_EXC_CODE`, 4: `rstatus` value on mult overflow.
- `DIV_EXC_CODE`, 5: `rstatus` value on divide-by-zero.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `load_multdiv_operands` in 1: decode holds a mult/div instruction this cycle.
- `is_div` in 1: ALU-op LSB (`ir[2]`); 1 = div, 0 = mult.
- `rd_in` in 5: destination register (`ir[26:22]`).
- `op_a` in 32, `op_b` in 32: register-file read data for rs/rt.
- `md_ready` in 1: unit result valid (one-cycle pulse).
- `md_result` in 32: unit result.
- `md_exception` in 1: unit exception, qualified by `md_ready`.
- `ctrl_mult` out 1, `ctrl_div` out 1: one-cycle start pulses.
- `md_op_a` out 32, `md_op_b` out 32: latched operands, held stable while busy.
- `stall` out 1: freeze PC and F/D latch.
- `wb_valid` out 1: write-port request.
- `wb_reg` out 5, `wb_data` out 32: write target and data.
- `wb_grant` in 1: write port granted this cycle.
- `busy` out 1: state ≠ IDLE.

## Operation
State machine IDLE → START → WAIT → WB → IDLE.

- **IDLE:**
  - If `load_multdiv_operands` is high, capture `op_a`, `op_b`, `rd_in` and `is_div`, then go to START.
  - `md_ready` is ignored in IDLE.
- **START:**
  - Drive `ctrl_div` = `kind`, `ctrl_mult` = `~kind` for exactly this cycle.
  - Clear the cycle counter and go to WAIT.
- **WAIT:**
  - Increment the counter.
  - On `md_ready`, capture the result and exception flag, then:
    - exception: `wb_reg` = `RSTATUS_REG`, `wb_data` = `DIV_EXC_CODE` (div) or `MULT_EXC_CODE` (mult);
    - no exception: `wb_reg` = latched rd, `wb_data` = `md_result`.
  - If there is no exception and rd = 0, go directly to IDLE (the r0 write is suppressed). Otherwise go to WB.
- **WB:**
  - Hold `wb_valid` = 1 with `wb_reg`/`wb_data` stable until `wb_grant` = 1.
  - In the grant cycle, go to IDLE.
- **Outputs and boundaries:**
  - `stall` = `busy` = (state ≠ IDLE), combinational from state.
  - `load_multdiv_operands` in a non-IDLE state is ignored; decode is frozen by `stall`.
  - `wb_grant` outside WB is ignored.
  - The counter saturates at its maximum and never wraps.
- **Reset:**
  - Asserted in any state, reset forces IDLE on the next edge. Any in-flight result is discarded.
  - Reset values: `ctrl_mult`=0, `ctrl_div`=0, `md_op_a`=0, `md_op_b`=0, `stall`=0, `wb_valid`=0, `wb_reg`=0, `wb_data`=0, `busy`=0.

## Timing
- Load seen at edge T: operands are valid on `md_op_*` from T+1.
- Start pulse in cycle T+1; `stall` is high from T+1.
- `md_ready` in cycle R: `wb_valid` rises in R+1.
- Grant in cycle G: `stall` low in G+1.
- Best-case occupancy: `LATENCY` + 3 cycles with immediate grant.
- Back-to-back mult/div: the second load is accepted in the first IDLE cycle after the first operation completes.

## Configuration
- `MULTDIV_WATCHDOG_EN` defined:
  - If the counter in WAIT reaches 2·`LATENCY` without `md_ready`, treat it as an exception and go to WB with the `rstatus` code for the current kind.
  - A late `md_ready` after that point is ignored.
- Undefined: WAIT lasts indefinitely until `md_ready`. The counter is still present but unused and may be optimized away.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding (2-bit enum IDLE=0, START=1, WAIT=2, WB=3);
  - `RSTATUS_REG`;
  - the exception codes;
  - the mult/div ALU-op constants (00110, 00111).
- Counter width is `$clog2(2*LATENCY+1)`.
- No sub-module; a single FSM plus operand/writeback registers.

## Test plan
- Mult 6×7, rd=3, `md_ready` at LATENCY: `ctrl_mult` pulses once; `stall` stays high through the grant cycle; write r3=42.
- Div 100/7, rd=5: `ctrl_div` pulses; write r5=14; `md_op_a`=100 stable for the whole operation.
- Div 9/0 with `md_exception`=1: write r30=5. Mult overflow: write r30=4.
- Mult with rd=0, no exception: no `wb_valid`; IDLE one cycle after `md_ready`.
- `wb_grant` delayed 3 cycles: `wb_valid`, `wb_reg` and `wb_data` stay constant; `stall` drops exactly one cycle after the grant.
- Reset low mid-WAIT, then `md_ready` arrives: all outputs 0; the late ready is ignored. With `MULTDIV_WATCHDOG_EN` and no ready: r30=code after 2·`LATENCY` WAIT cycles.
